lfa_share_arbiter: RTL

//  Shares one combinational 27-bit Ladner-Fischer adder (UBLFA_26_0_26_0 class) among

---
 rtl/lfa_share_arbiter_if.sv | 31 +++
 rtl/lfa_share_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/lfa_share_arbiter_if.sv
// Request, shared-adder and response signals of the LFA share arbiter.
// The arbiter takes the slave side; clients and the adder together form the master side.
interface lfa_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 27
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_x;
    logic [WIDTH-1:0]      add_y;
    logic [WIDTH:0]        add_s;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH:0]        resp_sum;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, add_s, resp_ready,
        output req_ready, add_x, add_y, resp_valid, resp_sum, resp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, add_s, resp_ready,
        input  req_ready, add_x, add_y, resp_valid, resp_sum, resp_id, busy
    );
endinterface

// File: rtl/lfa_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among NREQ clients:
// latch operands, hold them for SETTLE_CYC cycles, capture the sum and return it tagged.
module lfa_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 27,
    parameter int SETTLE_CYC = 1
) (
    input logic                clk,
    input logic                rst_n,
    lfa_share_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH:0]    resp_sum_q, resp_sum_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [NREQ-1:0]   req_ready_d;

    // Search ptr+NREQ down to ptr+1 so the last hit is the one closest after ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_sum_d  = resp_sum_q;
        resp_id_d   = resp_id_q;
        req_ready_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready_d = NREQ'(1) << grant_idx;
                    op_a_d      = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    op_b_d      = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d        = grant_idx;
                    cnt_d       = CNT_W'(SETTLE_CYC - 1);
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_sum_d = bus.add_s;
                    resp_id_d  = id_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    ptr_d   = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_W'(NREQ - 1);
            id_q       <= '0;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            resp_sum_q <= '0;
            resp_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            resp_sum_q <= resp_sum_d;
            resp_id_q  <= resp_id_d;
        end
    end

    // Operand registers drive the adder directly, so add_x/add_y stay put from SETTLE through RESP.
    assign bus.req_ready  = req_ready_d;
    assign bus.add_x      = op_a_q;
    assign bus.add_y      = op_b_q;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
